intadd_wb: RTL and testbench

- Writeback stage directly downstream of the SIMD integer adder.
- Snoops the adder's issue micro-instruction (cru_intadd) and the destination register addresses, then captures dst_reg0/dst_reg1/st when the adder's registered result is valid.
- Buffers results in a small FIFO and drains them through a single register-file write port with a valid/ready handshake.
- Maintains a sticky saturation/status accumulator and back-pressures the issue stage.

---
 rtl/intadd_wb_if.sv | 13 +
 rtl/intadd_wb.sv | 195 +++++++++++++++++++
 tb/tb_intadd_wb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intadd_wb_if.sv
// Register-file write port driven by the integer-adder writeback stage.
interface intadd_wb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 128
);
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_wr_ready;

  modport master (output rf_wr_en, rf_wr_addr, rf_wr_data, input rf_wr_ready);
  modport slave  (input rf_wr_en, rf_wr_addr, rf_wr_data, output rf_wr_ready);
endinterface

// File: rtl/intadd_wb.sv
// Writeback stage behind the SIMD integer adder: capture, result FIFO, RF write drain.
// Optional INTADD_WB_BYPASS_EN: write straight through when the FIFO and the drain are idle.
module intadd_wb #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 5,
  parameter  int DATA_W = 128,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [10:0]        cru_intadd,
  input  logic [ADDR_W-1:0]  dst0_addr,
  input  logic [ADDR_W-1:0]  dst1_addr,
  input  logic [DATA_W-1:0]  dst_reg0,
  input  logic [DATA_W-1:0]  dst_reg1,
  input  logic [DATA_W-1:0]  st,
  output logic               issue_stall,
  intadd_wb_if.master        rf,
  input  logic               st_clr,
  output logic [DATA_W-1:0]  st_sticky,
  output logic [CNT_W-1:0]   fifo_cnt,
  output logic               ovf_err
);

  // state | meaning
  // IDLE  | nothing being written
  // WR0   | writing addr0/dst_reg0 of the FIFO head
  // WR1   | writing addr1/dst_reg1 of the FIFO head (dual-beat entries)
  typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

  logic              inst_valid, update_st, prec_ok, accept;
  logic [1:0]        prec_s0;
  logic              unused_cru;

  logic              pend_valid_q, pend_dual_q, pend_upd_q;
  logic [ADDR_W-1:0] pend_addr0_q, pend_addr1_q;

  logic              ent_dual  [DEPTH];
  logic [ADDR_W-1:0] ent_addr0 [DEPTH];
  logic [ADDR_W-1:0] ent_addr1 [DEPTH];
  logic [DATA_W-1:0] ent_d0    [DEPTH];
  logic [DATA_W-1:0] ent_d1    [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt, occ;
  logic [DATA_W-1:0] st_q;
  logic              ovf_q;

  state_t            state_q;
  logic              en_q;
  logic              head_dual, push, pop;
  logic              byp_act, byp_skip, byp_dual;

  assign inst_valid = cru_intadd[10];
  assign prec_s0    = cru_intadd[9:8];
  assign update_st  = cru_intadd[0];
  assign unused_cru = ^cru_intadd[7:1];

  assign prec_ok     = (prec_s0 == 2'b00) || (prec_s0 == 2'b11);
  assign occ         = cnt_q + CNT_W'(pend_valid_q);
  assign issue_stall = occ >= CNT_W'(DEPTH - 1);
  assign accept      = inst_valid && !issue_stall;

  assign head_dual = ent_dual[rd_ptr_q];

`ifdef INTADD_WB_BYPASS_EN
  // Result arriving into an idle, empty stage goes straight to the write port.
  assign byp_act = pend_valid_q && (cnt_q == '0) && (state_q == IDLE);
`else
  assign byp_act = 1'b0;
`endif
  assign byp_skip = byp_act && rf.rf_wr_ready && !pend_dual_q;
  assign byp_dual = byp_act && rf.rf_wr_ready && pend_dual_q;

  assign push = pend_valid_q && !byp_skip;
  assign pop  = en_q && rf.rf_wr_ready && ((state_q == WR1) || !head_dual);

  always_comb begin
    cnt_nxt = cnt_q;
    if (push && !pop)
      cnt_nxt = cnt_q + CNT_W'(1);
    else if (pop && !push)
      cnt_nxt = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_dual[wr_ptr_q]  <= pend_dual_q;
      ent_addr0[wr_ptr_q] <= pend_addr0_q;
      ent_addr1[wr_ptr_q] <= pend_addr1_q;
      ent_d0[wr_ptr_q]    <= dst_reg0;
      ent_d1[wr_ptr_q]    <= dst_reg1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_dual_q  <= 1'b0;
      pend_upd_q   <= 1'b0;
      pend_addr0_q <= '0;
      pend_addr1_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      st_q         <= '0;
      ovf_q        <= 1'b0;
    end else begin
      pend_valid_q <= accept && prec_ok;
      if (accept) begin
        pend_dual_q  <= (prec_s0 == 2'b00);
        pend_upd_q   <= update_st;
        pend_addr0_q <= dst0_addr;
        pend_addr1_q <= dst1_addr;
      end
      if ((inst_valid && issue_stall) || (accept && !prec_ok))
        ovf_q <= 1'b1;
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_nxt;
      // Status follows the adder result even when the bypass path skips storage.
      if (pend_valid_q)
        st_q <= (st_clr ? '0 : st_q) | (pend_upd_q ? st : '0);
      else if (st_clr)
        st_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (byp_dual) begin
            state_q <= WR1;
            en_q    <= 1'b1;
          end else if (cnt_nxt != '0) begin
            state_q <= WR0;
            en_q    <= 1'b1;
          end
        end
        WR0: begin
          if (rf.rf_wr_ready) begin
            if (head_dual) begin
              state_q <= WR1;
              en_q    <= 1'b1;
            end else if (cnt_nxt != '0) begin
              state_q <= WR0;
              en_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
              en_q    <= 1'b0;
            end
          end
        end
        WR1: begin
          if (rf.rf_wr_ready) begin
            if (cnt_nxt != '0) begin
              state_q <= WR0;
              en_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
              en_q    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rf.rf_wr_en   = en_q | byp_act;
  assign rf.rf_wr_addr = byp_act           ? pend_addr0_q        :
                         !en_q             ? '0                  :
                         (state_q == WR1)  ? ent_addr1[rd_ptr_q] : ent_addr0[rd_ptr_q];
  assign rf.rf_wr_data = byp_act           ? dst_reg0            :
                         !en_q             ? '0                  :
                         (state_q == WR1)  ? ent_d1[rd_ptr_q]    : ent_d0[rd_ptr_q];

  assign st_sticky = st_q;
  assign fifo_cnt  = cnt_q;
  assign ovf_err   = ovf_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_intadd_wb.sv
// Directed and randomized bench for intadd_wb (default build, bypass disabled).
module tb_intadd_wb;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [10:0]       cru_intadd;
  logic [ADDR_W-1:0] dst0_addr, dst1_addr;
  logic [DATA_W-1:0] dst_reg0, dst_reg1, st;
  logic              issue_stall, st_clr, ovf_err;
  logic [DATA_W-1:0] st_sticky;
  logic [2:0]        fifo_cnt;

  intadd_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rf_bus ();

  intadd_wb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cru_intadd (cru_intadd),
    .dst0_addr  (dst0_addr),
    .dst1_addr  (dst1_addr),
    .dst_reg0   (dst_reg0),
    .dst_reg1   (dst_reg1),
    .st         (st),
    .issue_stall(issue_stall),
    .rf         (rf_bus),
    .st_clr     (st_clr),
    .st_sticky  (st_sticky),
    .fifo_cnt   (fifo_cnt),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic rdy = 1'b0;
  logic [DATA_W-1:0] h_r0 = '0, h_r1 = '0, h_st = '0;
  logic [ADDR_W-1:0] obs_addr [$];
  logic [DATA_W-1:0] obs_data [$];

  always @(negedge clk) begin
    if (rf_bus.rf_wr_en === 1'b1 && rf_bus.rf_wr_ready === 1'b1) begin
      obs_addr.push_back(rf_bus.rf_wr_addr);
      obs_data.push_back(rf_bus.rf_wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: present the previous instruction's adder results, issue a new one.
  task automatic step(input logic iv, input logic [1:0] prec, input logic upd,
                      input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic [127:0] r0, input logic [127:0] r1, input logic [127:0] s,
                      input logic clr, input logic polite, output logic issued);
    @(posedge clk);
    #1;
    dst_reg0 = h_r0;
    dst_reg1 = h_r1;
    st       = h_st;
    rf_bus.rf_wr_ready = rdy;
    issued     = iv && !(polite && issue_stall);
    cru_intadd = {issued, prec, 7'b0, upd};
    dst0_addr  = a0;
    dst1_addr  = a1;
    st_clr     = clr;
    h_r0 = r0;
    h_r1 = r1;
    h_st = s;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++)
      step(1'b0, 2'b00, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cru_intadd = '0;
    dst0_addr = '0;
    dst1_addr = '0;
    dst_reg0 = '0;
    dst_reg1 = '0;
    st = '0;
    st_clr = 1'b0;
    rdy = 1'b0;
    rf_bus.rf_wr_ready = 1'b0;
    h_r0 = '0;
    h_r1 = '0;
    h_st = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic              iss;
    int                n_iss;
    logic [127:0]      d0, d1, exp_st;
    logic              ill;
    logic [ADDR_W-1:0] ea [$];
    logic [127:0]      ed [$];

    do_reset();
    chk("rst_wr_en", 128'(rf_bus.rf_wr_en), '0);
    chk("rst_fifo_cnt", 128'(fifo_cnt), '0);
    chk("rst_sticky", st_sticky, '0);
    chk("rst_ovf", 128'(ovf_err), '0);
    chk("rst_stall", 128'(issue_stall), '0);

    // 32-bit single beat: write appears two cycles after issue
    rdy = 1'b1;
    d0 = {4{32'h7FFF_FFFF}};
    step(1'b1, 2'b11, 1'b0, 5'd3, 5'd9, d0, r128(), r128(), 1'b0, 1'b1, iss);
    chk("t32_issued", 128'(iss), 128'(1));
    idle(1);
    chk("t32_no_early_wr", 128'(rf_bus.rf_wr_en), '0);
    idle(1);
    chk("t32_wr_en", 128'(rf_bus.rf_wr_en), 128'(1));
    chk("t32_wr_addr", 128'(rf_bus.rf_wr_addr), 128'(3));
    chk("t32_wr_data", rf_bus.rf_wr_data, d0);
    idle(1);
    chk("t32_fifo_cnt", 128'(fifo_cnt), '0);
    chk("t32_wr_done", 128'(rf_bus.rf_wr_en), '0);
    chk("t32_beats", 128'(obs_addr.size()), 128'(1));

    // dual beat: addr 4 then 5
    obs_addr.delete();
    obs_data.delete();
    d0 = r128();
    d1 = r128();
    step(1'b1, 2'b00, 1'b0, 5'd4, 5'd5, d0, d1, r128(), 1'b0, 1'b1, iss);
    idle(2);
    chk("dual_b0_addr", 128'(rf_bus.rf_wr_addr), 128'(4));
    chk("dual_b0_data", rf_bus.rf_wr_data, d0);
    idle(1);
    chk("dual_b1_en", 128'(rf_bus.rf_wr_en), 128'(1));
    chk("dual_b1_addr", 128'(rf_bus.rf_wr_addr), 128'(5));
    chk("dual_b1_data", rf_bus.rf_wr_data, d1);
    idle(1);
    chk("dual_done", 128'(rf_bus.rf_wr_en), '0);
    chk("dual_beats", 128'(obs_addr.size()), 128'(2));

    // sticky status accumulate and clear
    step(1'b1, 2'b11, 1'b1, 5'd1, 5'd0, r128(), '0, 128'h01, 1'b0, 1'b1, iss);
    step(1'b1, 2'b11, 1'b1, 5'd2, 5'd0, r128(), '0, 128'h10, 1'b0, 1'b1, iss);
    idle(2);
    chk("sticky_or", st_sticky, 128'h11);
    step(1'b1, 2'b11, 1'b1, 5'd3, 5'd0, r128(), '0, 128'h04, 1'b0, 1'b1, iss);
    step(1'b0, 2'b00, 1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b1, iss);
    idle(1);
    chk("sticky_clr_push", st_sticky, 128'h04);
    step(1'b0, 2'b00, 1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b1, iss);
    idle(1);
    chk("sticky_clr_only", st_sticky, '0);

    // back-pressure with the register file stalled
    idle(2);
    obs_addr.delete();
    obs_data.delete();
    rdy = 1'b0;
    n_iss = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b11, 1'b0, 5'(10 + i), '0, 128'(32'hA000_0000 + 32'(i)), '0, '0,
           1'b0, 1'b1, iss);
      if (iss) n_iss++;
    end
    chk("stall_issued", 128'(n_iss), 128'(3));
    chk("stall_flag", 128'(issue_stall), 128'(1));
    chk("stall_fifo_cnt", 128'(fifo_cnt), 128'(3));
    chk("stall_hold_addr", 128'(rf_bus.rf_wr_addr), 128'(10));
    chk("stall_no_beats", 128'(obs_addr.size()), '0);
    chk("stall_no_ovf", 128'(ovf_err), '0);
    step(1'b1, 2'b11, 1'b0, 5'd20, '0, r128(), '0, '0, 1'b0, 1'b0, iss);
    idle(1);
    chk("drop_ovf", 128'(ovf_err), 128'(1));
    rdy = 1'b1;
    idle(6);
    chk("release_beats", 128'(obs_addr.size()), 128'(3));
    for (int k = 0; k < 3 && k < obs_addr.size(); k++) begin
      chk("release_addr", 128'(obs_addr[k]), 128'(10 + k));
      chk("release_data", obs_data[k], 128'(32'hA000_0000 + 32'(k)));
    end
    chk("release_fifo_cnt", 128'(fifo_cnt), '0);

    // illegal precision is discarded
    do_reset();
    obs_addr.delete();
    obs_data.delete();
    rdy = 1'b1;
    step(1'b1, 2'b01, 1'b1, 5'd6, 5'd7, r128(), r128(), 128'hFF, 1'b0, 1'b1, iss);
    idle(3);
    chk("illegal_ovf", 128'(ovf_err), 128'(1));
    chk("illegal_no_beats", 128'(obs_addr.size()), '0);
    chk("illegal_no_status", st_sticky, '0);

    // random traffic against an in-order write queue model
    do_reset();
    obs_addr.delete();
    obs_data.delete();
    exp_st = '0;
    ill = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      logic [1:0] pr;
      logic up;
      logic [ADDR_W-1:0] a0, a1;
      logic [127:0] r0, r1, s;
      rdy = ($urandom_range(3) != 0);
      sel = $urandom_range(15);
      pr = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : (sel[0] ? 2'b11 : 2'b00);
      up = 1'($urandom_range(1));
      a0 = 5'($urandom);
      a1 = 5'($urandom);
      r0 = r128();
      r1 = r128();
      s  = r128();
      step($urandom_range(2) != 0, pr, up, a0, a1, r0, r1, s, 1'b0, 1'b1, iss);
      if (iss) begin
        if (pr == 2'b00 || pr == 2'b11) begin
          ea.push_back(a0);
          ed.push_back(r0);
          if (pr == 2'b00) begin
            ea.push_back(a1);
            ed.push_back(r1);
          end
          if (up) exp_st |= s;
        end else begin
          ill = 1'b1;
        end
      end
    end
    rdy = 1'b1;
    idle(16);
    chk("rnd_beats", 128'(obs_addr.size()), 128'(ea.size()));
    for (int k = 0; k < ea.size() && k < obs_addr.size(); k++) begin
      chk("rnd_addr", 128'(obs_addr[k]), 128'(ea[k]));
      chk("rnd_data", obs_data[k], ed[k]);
    end
    chk("rnd_fifo_cnt", 128'(fifo_cnt), '0);
    chk("rnd_sticky", st_sticky, exp_st);
    chk("rnd_ovf", 128'(ovf_err), 128'(ill));

    // asynchronous reset while the second beat is waiting
    rdy = 1'b0;
    step(1'b1, 2'b00, 1'b1, 5'd7, 5'd8, r128(), r128(), 128'hF0, 1'b0, 1'b1, iss);
    idle(2);
    chk("wr1_pre_addr0", 128'(rf_bus.rf_wr_addr), 128'(7));
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    idle(1);
    chk("wr1_en", 128'(rf_bus.rf_wr_en), 128'(1));
    chk("wr1_addr", 128'(rf_bus.rf_wr_addr), 128'(8));
    chk("wr1_sticky", st_sticky, exp_st | 128'hF0);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 128'(rf_bus.rf_wr_en), '0);
    chk("arst_fifo_cnt", 128'(fifo_cnt), '0);
    chk("arst_sticky", st_sticky, '0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
